// File: rtl/alu_writeback_if.sv
// Handshake bus between the ALU, the writeback stage and the register-file write port.
// The master side is the environment (ALU driver plus register file); the slave side is the stage.
interface alu_writeback_if #(
  parameter int DATA_W  = 16,
  parameter int RADDR_W = 3
);
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  in_result;
  logic [3:0]         in_cc;
  logic               in_wen;
  logic [RADDR_W-1:0] in_dst;
  logic               in_setcc;
  logic               in_branch;
  logic [3:0]         in_cond;
  logic [DATA_W-1:0]  in_target;

  logic               wb_valid;
  logic               wb_ready;
  logic [RADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0]  wb_data;

  modport master (
    output in_valid, in_result, in_cc, in_wen, in_dst,
           in_setcc, in_branch, in_cond, in_target,
    input  in_ready,
    output wb_ready,
    input  wb_valid, wb_addr, wb_data
  );

  modport slave (
    input  in_valid, in_result, in_cc, in_wen, in_dst,
           in_setcc, in_branch, in_cond, in_target,
    output in_ready,
    input  wb_ready,
    output wb_valid, wb_addr, wb_data
  );
endinterface

// File: rtl/alu_writeback.sv
// Writeback stage behind the ALU: commits condition codes, resolves branches against
// the committed flags, and buffers register writes in a 2-entry FIFO toward a shared,
// back-pressuring write port. A saturating counter tracks cycles the port stalled us.
module alu_writeback #(
  parameter int DATA_W  = 16,
  parameter int RADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  alu_writeback_if.slave    bus,
  output logic [3:0]        cc_q,
  output logic              br_taken,
  output logic [DATA_W-1:0] br_target,
  output logic [15:0]       stall_cnt
);

  typedef enum logic [3:0] {
    COND_AL = 4'd0,
    COND_EQ = 4'd1,
    COND_NE = 4'd2,
    COND_LT = 4'd3,
    COND_GE = 4'd4,
    COND_CS = 4'd5,
    COND_CC = 4'd6,
    COND_MI = 4'd7,
    COND_PL = 4'd8,
    COND_VS = 4'd9,
    COND_VC = 4'd10,
    COND_GT = 4'd11,
    COND_LE = 4'd12,
    COND_NV13 = 4'd13,
    COND_NV14 = 4'd14,
    COND_NV15 = 4'd15
  } cond_e;

  logic [RADDR_W-1:0] buf_addr [2];
  logic [DATA_W-1:0]  buf_data [2];
  logic               wr_ptr;
  logic               rd_ptr;
  logic [1:0]         count;

  logic  accept;
  logic  push;
  logic  pop;
  logic  cond_true;
  cond_e cond;
  logic  flag_n, flag_z, flag_c, flag_v;

  // Ready only depends on registered occupancy, so upstream never sees a combinational loop.
  assign bus.in_ready = (count != 2'd2);
  assign bus.wb_valid = (count != 2'd0);
  assign bus.wb_addr  = buf_addr[rd_ptr];
  assign bus.wb_data  = buf_data[rd_ptr];

  assign accept = bus.in_valid & bus.in_ready;
  assign push   = accept & bus.in_wen;
  assign pop    = bus.wb_valid & bus.wb_ready;

  assign cond   = cond_e'(bus.in_cond);
  assign flag_n = cc_q[3];
  assign flag_z = cc_q[2];
  assign flag_c = cc_q[1];
  assign flag_v = cc_q[0];

  // Branch condition decode against the flags committed before this edge.
  always_comb begin
    cond_true = 1'b0;
    case (cond)
      COND_AL: cond_true = 1'b1;
      COND_EQ: cond_true = flag_z;
      COND_NE: cond_true = ~flag_z;
      COND_LT: cond_true = flag_n ^ flag_v;
      COND_GE: cond_true = ~(flag_n ^ flag_v);
      COND_CS: cond_true = flag_c;
      COND_CC: cond_true = ~flag_c;
      COND_MI: cond_true = flag_n;
      COND_PL: cond_true = ~flag_n;
      COND_VS: cond_true = flag_v;
      COND_VC: cond_true = ~flag_v;
      COND_GT: cond_true = ~flag_z & ~(flag_n ^ flag_v);
      COND_LE: cond_true = flag_z | (flag_n ^ flag_v);
      default: cond_true = 1'b0;
    endcase
  end

  // Write FIFO: storage, pointers and occupancy; push and pop together leave count unchanged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        buf_addr[i] <= '0;
        buf_data[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        buf_addr[wr_ptr] <= bus.in_dst;
        buf_data[wr_ptr] <= bus.in_result;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Architectural condition-code register, updated only by accepted setcc instructions.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cc_q <= 4'b0000;
    end else if (accept && bus.in_setcc) begin
      cc_q <= bus.in_cc;
    end
  end

  // Branch resolution: one-cycle taken pulse, target remembered from the last taken branch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      br_taken  <= 1'b0;
      br_target <= '0;
    end else if (accept && bus.in_branch && cond_true) begin
      br_taken  <= 1'b1;
      br_target <= bus.in_target;
    end else begin
      br_taken  <= 1'b0;
    end
  end

  // Stall counter: cycles where a write is pending but the port refuses it, saturating.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= 16'd0;
    end else if (bus.wb_valid && !bus.wb_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: doc/alu_writeback.md
# alu_writeback

Writeback stage directly downstream of the 16-bit ALU. Accepts one executed instruction per cycle (ALU `result`/`cc` plus control), commits the N,Z,C,V condition codes into an architectural CC register, evaluates branch conditions against the committed flags, and queues register-file writes in a 2-entry buffer toward a shared write port that can back-pressure. A saturating stall counter supports performance debug.

## Interface
- `DATA_W`, 16, datapath width; matches the ALU result width.
- `RADDR_W`, 3, register-file address width (8 registers).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  executed instruction present on the `in_*` bus.
- `in_ready`  out  1  stage can accept; transfer when `in_valid & in_ready`.
- `in_result`  in  DATA_W  ALU result.
- `in_cc`  in  4  ALU flags {N,Z,C,V}.
- `in_wen`  in  1  instruction writes a register.
- `in_dst`  in  RADDR_W  destination register.
- `in_setcc`  in  1  instruction updates the CC register.
- `in_branch`  in  1  instruction is a conditional branch.
- `in_cond`  in  4  branch condition code.
- `in_target`  in  DATA_W  branch target address.
- `wb_valid`  out  1  head write pending.
- `wb_ready`  in  1  register file accepts the write this cycle.
- `wb_addr`  out  RADDR_W  head write address.
- `wb_data`  out  DATA_W  head write data.
- `cc_q`  out  4  committed {N,Z,C,V}.
- `br_taken`  out  1  one-cycle pulse: accepted branch resolved taken.
- `br_target`  out  DATA_W  target of the most recent taken branch.
- `stall_cnt`  out  16  saturating count of cycles with `wb_valid & ~wb_ready`.

## Operation
- Write buffer: 2-entry FIFO of {addr,data}; `count` in 0..2; `in_ready = (count != 2)`, combinational from registered `count`, independent of `in_valid`/`wb_ready`.
- Push: accepted instruction with `in_wen=1`. Accepted instructions with `in_wen=0` are consumed without occupying the buffer.
- Pop: `wb_valid & wb_ready`; `wb_valid = (count != 0)`; `wb_addr`/`wb_data` show the oldest entry.
- Push and pop in the same cycle: count unchanged, ordering preserved (FIFO, oldest written first). At count=2 no push occurs (in_ready=0), pop alone allowed.
- CC register: on accept with `in_setcc=1`, `cc_q <= in_cc`; otherwise holds. Branches never update CC unless `in_setcc=1` (reserved; undefined use).
- Branch evaluation on accept with `in_branch=1`, using `cc_q` as registered before this edge (flags of all previously accepted instructions):
  - 0 always; 1 EQ Z; 2 NE ~Z; 3 LT N^V; 4 GE ~(N^V); 5 CS C; 6 CC ~C; 7 MI N; 8 PL ~N; 9 VS V; 10 VC ~V; 11 GT ~Z&~(N^V); 12 LE Z|(N^V); 13-15 never.
  - Taken: `br_taken <= 1`, `br_target <= in_target`. Else `br_taken <= 0`, `br_target` holds.
- `br_taken` is 0 in every cycle not following a taken-branch accept.
- `stall_cnt` increments each cycle `wb_valid & ~wb_ready`, saturates at 16'hFFFF, never wraps.

## Timing
- Reset (async assert, sync-to-clk deassert upstream): count=0, buffer contents 0, `wb_valid=0`, `wb_addr=0`, `wb_data=0`, `in_ready=1`, `cc_q=4'b0000`, `br_taken=0`, `br_target=0`, `stall_cnt=0`.
- Reset mid-operation: pending writes discarded, no `wb_valid` after release until a new push.
- Accept-to-`wb_valid` latency: 1 cycle when buffer empty. Accept-to-`cc_q` update: 1 cycle. Accept-to-`br_taken`: 1 cycle.
- Back-to-back: setcc instruction at cycle t, branch at t+1 sees the new flags.
- Throughput: 1 instruction/cycle while `wb_ready=1`; with `wb_ready=0`, two writes absorbed then `in_ready` drops the following cycle.

## Test plan
- Reset: hold `reset_n=0` mid-stream with count=2 -> all outputs at reset values, `in_ready=1`, no write emitted after release.
- Stream: 4 writes R1..R4 data 16'h0001..16'h0004, `wb_ready=1` -> `wb_valid` every cycle, writes in order, latency 1, count never >1.
- Backpressure: `wb_ready=0`, push R5=16'hAAAA, R6=16'h5555 -> `in_ready=0` after second, `stall_cnt` increments per cycle; raise `wb_ready` -> R5 then R6, `in_ready` returns 1 after first pop.
- Simultaneous push/pop at count=1 -> count stays 1, order preserved.
- Flags/branch: accept SUB-like setcc with `in_cc=4'b0100`, next cycle branch cond 1 target 16'h0040 -> `br_taken=1`, `br_target=16'h0040`; then cond 2 -> no pulse, `br_target` holds 16'h0040; cond 3 with `cc_q=4'b1000` -> taken; cond 14 -> never.
- Saturation: force 65540 stall cycles -> `stall_cnt=16'hFFFF`, holds.
